// File: rtl/multi_channel_level_meter.sv
// rtl/multi_channel_level_meter.sv - interleaved multi-channel PCM level meter with decaying peak hold
module multi_channel_level_meter #(
    parameter int channel_count        = 2,
    parameter int sample_width         = 16,
    parameter int indicator_width      = 32,
    parameter int section_sample_count = 700,
    parameter int peak_hold_count      = 630,
    localparam int CW = (channel_count > 1) ? $clog2(channel_count) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [CW-1:0]               i_channel,
    input  logic [sample_width-1:0]     i_value,
    input  logic                        i_mode,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [CW-1:0]               o_channel,
    output logic [indicator_width-1:0]  o_array
);

    localparam int W  = sample_width;
    localparam int I  = indicator_width;
    localparam int LW = $clog2(I + 1);
    localparam int NW = (section_sample_count > 1) ? $clog2(section_sample_count) : 1;
    localparam int HW = (peak_hold_count > 0) ? $clog2(peak_hold_count + 1) : 1;
    localparam int PW = W + LW;

    localparam logic signed [W-1:0] MIN_INIT = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MAX_INIT = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] min_q  [channel_count];
    logic signed [W-1:0] max_q  [channel_count];
    logic [NW-1:0]       cnt_q  [channel_count];
    logic [LW-1:0]       peak_q [channel_count];
    logic [HW-1:0]       hold_q [channel_count];

    logic          o_valid_q;
    logic [CW-1:0] o_channel_q;
    logic [I-1:0]  o_array_q;

    logic                ch_ok;
    logic                accept;
    logic                closing;
    logic [CW-1:0]       idx;
    logic signed [W-1:0] sample;
    logic signed [W-1:0] min_d;
    logic signed [W-1:0] max_d;
    logic [NW-1:0]       cnt_d;
    logic [W-1:0]        abs_min;
    logic [W-1:0]        abs_max;
    logic [W:0]          twice;
    logic [W-1:0]        mag;
    logic [PW-1:0]       scaled;
    logic [LW-1:0]       level;
    logic [LW-1:0]       peak_d;
    logic [HW-1:0]       hold_d;
    logic [I-1:0]        array_d;

    assign i_ready   = ~o_valid_q | o_ready;
    assign o_valid   = o_valid_q;
    assign o_channel = o_channel_q;
    assign o_array   = o_array_q;

    assign sample = i_value;
    assign ch_ok  = 32'(i_channel) < channel_count;
    assign idx    = ch_ok ? i_channel : '0;
    assign accept = i_valid & i_ready & ch_ok;

    always_comb begin
        min_d   = (sample < min_q[idx]) ? sample : min_q[idx];
        max_d   = (sample > max_q[idx]) ? sample : max_q[idx];
        closing = (cnt_q[idx] == NW'(section_sample_count - 1));
        cnt_d   = closing ? '0 : cnt_q[idx] + 1'b1;

        // max >= min once a sample is folded in, so a W-bit wrap-around difference is exact
        abs_min = min_d[W-1] ? (~min_d + 1'b1) : min_d;
        abs_max = max_d[W-1] ? (~max_d + 1'b1) : max_d;
        twice   = (abs_min > abs_max) ? {abs_min, 1'b0} : {abs_max, 1'b0};
        if (i_mode) begin
            mag = twice[W] ? {W{1'b1}} : twice[W-1:0];
        end else begin
            mag = $unsigned(max_d) - $unsigned(min_d);
        end

        // ceil(m*I / 2^W): adding 2^W-1 before the shift cannot overflow PW bits
        scaled = {{LW{1'b0}}, mag} * PW'(I) + {{LW{1'b0}}, {W{1'b1}}};
        level  = LW'(scaled >> W);

        if (level >= peak_q[idx]) begin
            peak_d = level;
            hold_d = HW'(peak_hold_count);
        end else if (hold_q[idx] != '0) begin
            peak_d = peak_q[idx];
            hold_d = hold_q[idx] - 1'b1;
        end else begin
            peak_d = level;
            hold_d = hold_q[idx];
        end

        array_d = '0;
        for (int k = 0; k < I; k++) begin
            array_d[k] = (k < int'(level)) || ((peak_d != '0) && (k == int'(peak_d) - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < channel_count; c++) begin
                min_q[c]  <= MIN_INIT;
                max_q[c]  <= MAX_INIT;
                cnt_q[c]  <= '0;
                peak_q[c] <= '0;
                hold_q[c] <= '0;
            end
            o_valid_q   <= 1'b0;
            o_channel_q <= '0;
            o_array_q   <= '0;
        end else begin
            if (accept) begin
                cnt_q[idx] <= cnt_d;
                if (closing) begin
                    min_q[idx]  <= MIN_INIT;
                    max_q[idx]  <= MAX_INIT;
                    peak_q[idx] <= peak_d;
                    hold_q[idx] <= hold_d;
                end else begin
                    min_q[idx] <= min_d;
                    max_q[idx] <= max_d;
                end
            end
            // a new frame may overwrite the one being handed off in the same edge
            if (accept && closing) begin
                o_valid_q   <= 1'b1;
                o_channel_q <= idx;
                o_array_q   <= array_d;
            end else if (o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_level_meter.sv
// tb/tb_multi_channel_level_meter.sv - self-checking bench for multi_channel_level_meter
module tb_multi_channel_level_meter;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_ready;
    logic [0:0]         i_channel = '0;
    logic signed [15:0] i_value = '0;
    logic               i_mode = 1'b0;
    logic               o_valid;
    logic               o_ready = 1'b1;
    logic [0:0]         o_channel;
    logic [31:0]        o_array;

    typedef struct {
        logic [0:0]  ch;
        logic [31:0] arr;
    } frame_t;

    typedef struct {
        int          ch;
        int          val;
        logic        mode;
        logic        closes;
        logic [31:0] arr;
    } vec_t;

    frame_t sb[$];
    vec_t   tbl[$];
    int     total = 0;
    int     bad = 0;

    always #5 clk = ~clk;

    multi_channel_level_meter #(
        .channel_count(2),
        .sample_width(16),
        .indicator_width(32),
        .section_sample_count(4),
        .peak_hold_count(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_channel(i_channel),
        .i_value(i_value),
        .i_mode(i_mode),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_channel(o_channel),
        .o_array(o_array)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (!reset && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got ch=%0d arr=0x%08h want no frame", o_channel, o_array);
            end else begin
                f = sb.pop_front();
                chk("frame_channel", 64'(o_channel), 64'(f.ch));
                chk("frame_array", 64'(o_array), 64'(f.arr));
            end
        end
    end

    task automatic send(input int ch, input int val, input logic mode, input logic closes,
                        input logic [31:0] arr);
        int     n;
        frame_t f;
        n = 0;
        i_valid   = 1'b1;
        i_channel = 1'(ch);
        i_value   = 16'(val);
        i_mode    = mode;
        @(negedge clk);
        while (!i_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!i_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got i_ready=0 want 1");
            i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        if (closes) begin
            f.ch  = 1'(ch);
            f.arr = arr;
            sb.push_back(f);
        end
        chk("o_valid_after_accept", 64'(o_valid), 64'(closes));
        if (closes) chk("o_channel_latency", 64'(o_channel), 64'(ch));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_array", 64'(o_array), 64'd0);
        chk("rst_i_ready", 64'(i_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic add4(input int ch, input int a, input int b, input int c, input int d,
                        input logic mode_pre, input logic mode_close, input logic [31:0] arr);
        tbl.push_back('{ch, a, mode_pre, 1'b0, 32'h0});
        tbl.push_back('{ch, b, mode_pre, 1'b0, 32'h0});
        tbl.push_back('{ch, c, mode_pre, 1'b0, 32'h0});
        tbl.push_back('{ch, d, mode_close, 1'b1, arr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        add4(0,   1000,  -1000,  500,    0, 1'b0, 1'b0, 32'h0000_0001);
        add4(1,  32767, -32768,    0,    0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        add4(1, -16384,      0,    0,    0, 1'b1, 1'b1, 32'h8000_FFFF);
        add4(1,  32767, -32768,    0,    0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        add4(1,      0,      0,    0,    0, 1'b0, 1'b0, 32'h8000_0000);
        add4(1,      0,      0,    0,    0, 1'b0, 1'b0, 32'h8000_0000);
        add4(1,      0,      0,    0,    0, 1'b0, 1'b0, 32'h0000_0000);
        add4(0, -32768, -32768, -32768, -32768, 1'b1, 1'b1, 32'hFFFF_FFFF);
        add4(0,      5,      5,    5,    5, 1'b0, 1'b0, 32'h8000_0000);
        add4(1,      7,      7,    7,    7, 1'b0, 1'b0, 32'h0000_0000);
        add4(0,  16384,      0,    0,    0, 1'b1, 1'b0, 32'h8000_00FF);
        add4(0,   -100,    100,    0,    0, 1'b0, 1'b0, 32'h0000_0001);

        #1;
        chk("init_o_valid", 64'(o_valid), 64'd0);
        chk("init_o_array", 64'(o_array), 64'd0);
        chk("init_o_channel", 64'(o_channel), 64'd0);
        chk("init_i_ready", 64'(i_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // partial ch0 section plus a pending ch1 frame, both discarded by reset
        o_ready = 1'b0;
        send(0, 32767, 1'b0, 1'b0, 32'h0);
        send(0, -32768, 1'b0, 1'b0, 32'h0);
        send(1, 1000, 1'b0, 1'b0, 32'h0);
        send(1, 1000, 1'b0, 1'b0, 32'h0);
        send(1, 1000, 1'b0, 1'b0, 32'h0);
        send(1, 0, 1'b0, 1'b1, 32'h0000_0001);
        do_reset();
        o_ready = 1'b1;
        send(0, 10, 1'b0, 1'b0, 32'h0);
        send(0, 10, 1'b0, 1'b0, 32'h0);
        send(0, 10, 1'b0, 1'b0, 32'h0);
        send(0, 10, 1'b0, 1'b1, 32'h0);

        do_reset();
        foreach (tbl[i]) send(tbl[i].ch, tbl[i].val, tbl[i].mode, tbl[i].closes, tbl[i].arr);

        // interleaved channels with the first close stalled by the sink
        do_reset();
        o_ready = 1'b0;
        send(0, 100, 1'b0, 1'b0, 32'h0);
        send(1, 20000, 1'b0, 1'b0, 32'h0);
        send(0, -100, 1'b0, 1'b0, 32'h0);
        send(1, -20000, 1'b0, 1'b0, 32'h0);
        send(0, 0, 1'b0, 1'b0, 32'h0);
        send(1, 0, 1'b0, 1'b0, 32'h0);
        send(0, 0, 1'b0, 1'b1, 32'h0000_0001);
        i_valid   = 1'b1;
        i_channel = 1'b1;
        i_value   = 16'sd0;
        i_mode    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_i_ready", 64'(i_ready), 64'd0);
            chk("bp_o_array_stable", 64'(o_array), 64'h1);
            chk("bp_o_channel_stable", 64'(o_channel), 64'd0);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        sb.push_back('{1'b1, 32'h000F_FFFF});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("bp_replace_valid", 64'(o_valid), 64'd1);
        chk("bp_replace_channel", 64'(o_channel), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("o_valid_idle", 64'(o_valid), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
